data_cache_responder: RTL

Responder end of the CPU data-memory port (readM/writeM/address/data/hit). It sits between the pipelined data path and main memory as a direct-mapped, write-through, no-write-allocate cache.
- Read hits are served in the same cycle.
- Misses and all writes stall the CPU via hit=0 while a line fill or word write runs on the memory-side handshake.
- It also keeps hit/miss statistics counters.

---
 rtl/data_cache_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/data_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache on the CPU data-memory port.
// Read hits complete combinationally; misses and writes stall the CPU via hit=0.
module data_cache_responder #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned NUM_LINES  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            readM,
    input  logic                            writeM,
    input  logic [WORD_SIZE-1:0]            address,
    inout  wire  [WORD_SIZE-1:0]            data,
    output logic                            hit,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [WORD_SIZE-1:0]            mem_addr,
    output logic [WORD_SIZE-1:0]            mem_wdata,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_rdata,
    input  logic                            mem_ready,
    output logic [15:0]                     hit_count,
    output logic [15:0]                     miss_count
);

    localparam int unsigned TagW = WORD_SIZE - 4;

    typedef enum logic [1:0] {StIdle, StFill, StWrite, StWdone} state_e;

    state_e               state_q;
    logic                 valid_q [NUM_LINES];
    logic [TagW-1:0]      tag_q   [NUM_LINES];
    logic [WORD_SIZE-1:0] line_q  [NUM_LINES][LINE_WORDS];

    logic [1:0]           idx;
    logic                 read_hit;
    logic                 serve_rd;
    logic [1:0]           mem_idx;
    logic                 wr_line_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign idx      = address[3:2];
    assign read_hit = valid_q[idx] && (tag_q[idx] == address[WORD_SIZE-1:4]);
    assign serve_rd = (state_q == StIdle) && readM && read_hit && !reset;

    assign data = serve_rd ? line_q[idx][address[1:0]] : 'z;

    // Fill and write completion are keyed off the registered memory address.
    assign mem_idx     = mem_addr[3:2];
    assign wr_line_hit = valid_q[mem_idx] && (tag_q[mem_idx] == mem_addr[WORD_SIZE-1:4]);

    always_comb begin
        hit = 1'b1;
        case (state_q)
            StIdle:  hit = !(writeM || (readM && !read_hit));
            StFill:  hit = 1'b0;
            StWrite: hit = 1'b0;
            StWdone: hit = 1'b1;
            default: hit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            valid_q    <= '{default: 1'b0};
            tag_q      <= '{default: '0};
            line_q     <= '{default: '{default: '0}};
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (readM) begin
                        if (read_hit) begin
                            hit_count <= sat_inc(hit_count);
                        end else begin
                            state_q    <= StFill;
                            mem_read   <= 1'b1;
                            mem_addr   <= {address[WORD_SIZE-1:2], 2'b00};
                            miss_count <= sat_inc(miss_count);
                        end
                    end else if (writeM) begin
                        state_q   <= StWrite;
                        mem_write <= 1'b1;
                        mem_addr  <= address;
                        mem_wdata <= data;
                    end
                end
                StFill: begin
                    if (mem_ready) begin
                        for (int w = 0; w < LINE_WORDS; w++) begin
                            line_q[mem_idx][w] <= mem_rdata[w*WORD_SIZE +: WORD_SIZE];
                        end
                        valid_q[mem_idx] <= 1'b1;
                        tag_q[mem_idx]   <= mem_addr[WORD_SIZE-1:4];
                        mem_read         <= 1'b0;
                        state_q          <= StIdle;
                    end
                end
                StWrite: begin
                    if (mem_ready) begin
                        // Write-update only; a miss leaves the cache untouched.
                        if (wr_line_hit) begin
                            line_q[mem_idx][mem_addr[1:0]] <= mem_wdata;
                        end
                        mem_write <= 1'b0;
                        state_q   <= StWdone;
                    end
                end
                StWdone: begin
                    hit_count <= sat_inc(hit_count);
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
